// File: rtl/axi_lite_master_if.sv
// AXI4-Lite channel bundle (AW/W/B/AR/R) shared by an initiator and a register-block slave.
interface axi_lite_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one local request in, one AXI transaction out,
// one response back, with a watchdog that flags slaves stalling a channel.
module axi_lite_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              axi_clk,
  input  logic              axi_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_code,
  output logic              busy,
  output logic              timeout_err,
  axi_lite_master_if.master axi
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

  localparam int            WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [WD_W-1:0] wdog;
  logic            axi_hs;
  logic            wd_active;

  assign axi_hs = (axi.awvalid & axi.awready) | (axi.wvalid & axi.wready) |
                  (axi.bvalid & axi.bready) | (axi.arvalid & axi.arready) |
                  (axi.rvalid & axi.rready);
  assign wd_active = (state == WR) || (state == WR_RESP) ||
                     (state == RD_ADDR) || (state == RD_DATA);

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state       <= IDLE;
      wdog        <= '0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_write  <= 1'b0;
      resp_rdata  <= '0;
      resp_code   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            resp_write <= req_write;
            if (req_write) begin
              axi.awaddr  <= req_addr;
              axi.wdata   <= req_wdata;
              axi.wstrb   <= req_wstrb;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              state       <= WR;
            end else begin
              axi.araddr  <= req_addr;
              axi.arvalid <= 1'b1;
              state       <= RD_ADDR;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WR: begin
          // AW and W retire independently; a channel with valid low has already completed.
          if (axi.awvalid && axi.awready) axi.awvalid <= 1'b0;
          if (axi.wvalid && axi.wready) axi.wvalid <= 1'b0;
          if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) begin
            axi.bready <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.bvalid && axi.bready) begin
            resp_code  <= axi.bresp;
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            axi.bready <= 1'b0;
            state      <= RESP;
          end
        end
        RD_ADDR: begin
          if (axi.arvalid && axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.rvalid && axi.rready) begin
            resp_rdata <= axi.rdata;
            resp_code  <= axi.rresp;
            resp_valid <= 1'b1;
            axi.rready <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Watchdog only observes; it never touches a valid or the state.
      if (TIMEOUT_CYCLES == 0 || !wd_active || axi_hs) begin
        wdog <= '0;
      end else if (wdog == WD_LAST) begin
        wdog        <= '0;
        timeout_err <= 1'b1;
      end else begin
        wdog <= wdog + WD_W'(1);
      end
    end
  end

endmodule
